// File: rtl/mem_pkg.sv
// Shared types and constants for the wait-state data memory.
// Used by the top-level controller and its byte-enable RAM.
package mem_pkg;
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } mem_state_t;

   localparam int MEM_WORD_BYTES = 4;
endpackage

// File: rtl/be_ram.sv
// Single-port word RAM with a per-byte write mask and a registered read port.
// The read register holds its value unless a read is strobed.
module be_ram
   import mem_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   localparam int AW = $clog2(DEPTH_WORDS)
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      we_i,
   input  logic                      re_i,
   input  logic [MEM_WORD_BYTES-1:0] be_i,
   input  logic [AW-1:0]             addr_i,
   input  logic [31:0]               wd_i,
   output logic [31:0]               rd_o
);
   logic [31:0] r_mem [DEPTH_WORDS];
   logic [31:0] r_rd;

   // Byte-masked write; array contents are intentionally not reset.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         for (int n = 0; n < MEM_WORD_BYTES; n++) begin
            if (be_i[n]) begin
               r_mem[addr_i][8*n +: 8] <= wd_i[8*n +: 8];
            end
         end
      end
   end

   // Registered read word, held between reads.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_rd <= 32'h0;
      end else if (re_i) begin
         r_rd <= r_mem[addr_i];
      end
   end

   assign rd_o = r_rd;
endmodule

// File: rtl/data_mem_wait.sv
// Data memory with programmable wait states: one request at a time, held for
// LATENCY cycles, completed by a single-cycle ready pulse with the read word.
module data_mem_wait
   import mem_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [3:0]  be_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wd_i,
   output logic [31:0] rd_o,
   output logic        ready_o
);
   localparam int AW = $clog2(DEPTH_WORDS);
   localparam int CW = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
   localparam logic [CW-1:0] LAT_C = CW'(LATENCY);
   localparam logic [CW-1:0] CNT_ONE = CW'(32'd1);
   localparam logic [CW-1:0] CNT_ZERO = CW'(32'd0);

   mem_state_t    r_state, w_state_nxt;
   logic [CW-1:0] r_cnt, w_cnt_nxt;
   logic          r_ready, r_we, w_accept, w_commit, w_live, w_we_sel;
   logic [3:0]    r_be, w_be_sel;
   logic [AW-1:0] r_idx, w_idx_sel;
   logic [31:0]   r_wd, w_wd_sel;
   logic          w_unused_addr;

   assign w_unused_addr = ^{addr_i[31:AW+2], addr_i[1:0]};

   // Next-state and wait-counter logic.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_accept    = 1'b0;
      case (r_state)
         IDLE: begin
            if (req_i) begin
               w_accept    = 1'b1;
               w_cnt_nxt   = LAT_C;
               w_state_nxt = (LATENCY == 0) ? RESP : WAIT;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         WAIT: begin
            if (!req_i) begin
               w_cnt_nxt   = CNT_ZERO;
               w_state_nxt = IDLE;
            end else if (r_cnt <= CNT_ONE) begin
               w_cnt_nxt   = CNT_ZERO;
               w_state_nxt = RESP;
            end else begin
               w_cnt_nxt   = r_cnt - CNT_ONE;
               w_state_nxt = WAIT;
            end
         end
         RESP: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_cnt_nxt   = CNT_ZERO;
            w_state_nxt = IDLE;
         end
      endcase
   end

   // With zero latency the commit happens on the accept edge, before capture.
   assign w_commit  = (w_state_nxt == RESP);
   assign w_live    = (r_state == IDLE);
   assign w_we_sel  = w_live ? we_i : r_we;
   assign w_be_sel  = w_live ? be_i : r_be;
   assign w_idx_sel = w_live ? addr_i[AW+1:2] : r_idx;
   assign w_wd_sel  = w_live ? wd_i : r_wd;

   // State, counter, ready and request-capture registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= IDLE;
         r_cnt   <= CNT_ZERO;
         r_ready <= 1'b0;
         r_we    <= 1'b0;
         r_be    <= 4'b0000;
         r_idx   <= {AW{1'b0}};
         r_wd    <= 32'h0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_ready <= w_commit;
         if (w_accept) begin
            r_we  <= we_i;
            r_be  <= be_i;
            r_idx <= addr_i[AW+1:2];
            r_wd  <= wd_i;
         end
      end
   end

   be_ram #(
      .DEPTH_WORDS(DEPTH_WORDS)
   ) u_ram (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .we_i  (w_commit & w_we_sel),
      .re_i  (w_commit & ~w_we_sel),
      .be_i  (w_be_sel),
      .addr_i(w_idx_sel),
      .wd_i  (w_wd_sel),
      .rd_o  (rd_o)
   );

   assign ready_o = r_ready;
endmodule

// File: tb/tb_data_mem_wait.sv
// Bench for data_mem_wait: directed scenarios plus randomized traffic against
// a word-array reference model, on a LATENCY=2 and a LATENCY=0 instance.
module tb_data_mem_wait;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req2 = 1'b0, req0 = 1'b0, we = 1'b0;
   logic [3:0]  be = 4'b0000;
   logic [31:0] addr = 32'h0, wd = 32'h0;
   logic [31:0] rd2, rd0;
   logic        rdy2, rdy0;
   logic [31:0] mdl [1024];
   int          n_pass = 0, n_total = 0;

   always #5 clk = ~clk;

   data_mem_wait #(.DEPTH_WORDS(1024), .LATENCY(2)) dut2 (
      .clk_i(clk), .rst_i(rst), .req_i(req2), .we_i(we), .be_i(be),
      .addr_i(addr), .wd_i(wd), .rd_o(rd2), .ready_o(rdy2));

   data_mem_wait #(.DEPTH_WORDS(1024), .LATENCY(0)) dut0 (
      .clk_i(clk), .rst_i(rst), .req_i(req0), .we_i(we), .be_i(be),
      .addr_i(addr), .wd_i(wd), .rd_o(rd0), .ready_o(rdy0));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // One full transaction; request inputs are scrambled while it is pending.
   task automatic txn(input bit l0, input logic w, input logic [3:0] b,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] exp_rd, input string tag);
      int k;
      bit got;
      k = 0;
      got = 1'b0;
      we = w; be = b; addr = a; wd = d;
      if (l0) req0 = 1'b1;
      else req2 = 1'b1;
      while (!got && k < 20) begin
         @(negedge clk);
         k++;
         if (l0 ? rdy0 : rdy2) got = 1'b1;
         else begin
            we = ~w; be = 4'($urandom); addr = $urandom; wd = $urandom;
         end
      end
      chk({tag, "_lat"}, 32'(k), l0 ? 32'd1 : 32'd3);
      if (!w && got) chk({tag, "_rd"}, l0 ? rd0 : rd2, exp_rd);
      req0 = 1'b0;
      req2 = 1'b0;
      @(negedge clk);
      chk({tag, "_pulse"}, {31'd0, (l0 ? rdy0 : rdy2)}, 32'd0);
   endtask

   initial begin
      int idx, seen;
      logic [31:0] a, d;
      logic [3:0] b;

      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_rdy2", {31'd0, rdy2}, 32'd0);
      chk("rst_rd2", rd2, 32'h0);
      chk("rst_rdy0", {31'd0, rdy0}, 32'd0);
      chk("rst_rd0", rd0, 32'h0);

      txn(1'b0, 1'b1, 4'b1111, 32'h10, 32'hDEADBEEF, 32'h0, "wr10");
      txn(1'b0, 1'b0, 4'b0000, 32'h10, 32'h0, 32'hDEADBEEF, "rd10");

      txn(1'b0, 1'b1, 4'b1111, 32'h20, 32'h11223344, 32'h0, "wr20");
      txn(1'b0, 1'b1, 4'b0100, 32'h20, 32'hAAAAAAAA, 32'h0, "wr20p");
      txn(1'b0, 1'b0, 4'b1111, 32'h20, 32'h0, 32'h11AA3344, "rd20");

      txn(1'b0, 1'b1, 4'b1111, 32'h0000_1004, 32'h5A5A5A5A, 32'h0, "wrwrap");
      txn(1'b0, 1'b0, 4'b0000, 32'h0000_0006, 32'h0, 32'h5A5A5A5A, "rdwrap");

      // Abort a write during its wait phase.
      txn(1'b0, 1'b1, 4'b1111, 32'h30, 32'h01020304, 32'h0, "wr30");
      we = 1'b1; be = 4'b1111; addr = 32'h30; wd = 32'hFFFFFFFF; req2 = 1'b1;
      @(negedge clk);
      seen = int'(rdy2);
      req2 = 1'b0;
      repeat (4) begin
         @(negedge clk);
         seen += int'(rdy2);
      end
      chk("abort_noready", 32'(seen), 32'd0);
      txn(1'b0, 1'b0, 4'b0000, 32'h30, 32'h0, 32'h01020304, "rd30abort");

      // Reset while a read is completing.
      we = 1'b0; addr = 32'h20; req2 = 1'b1;
      repeat (3) @(negedge clk);
      chk("midrd_rdy_before", {31'd0, rdy2}, 32'd1);
      rst = 1'b1;
      req2 = 1'b0;
      #1;
      chk("midrd_rdy_rst", {31'd0, rdy2}, 32'd0);
      chk("midrd_rd_rst", rd2, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      txn(1'b0, 1'b0, 4'b0000, 32'h10, 32'h0, 32'hDEADBEEF, "rd10post");
      txn(1'b0, 1'b0, 4'b0000, 32'h30, 32'h0, 32'h01020304, "rd30post");

      // Randomized traffic on the LATENCY=2 instance.
      for (int k = 0; k < 8; k++) begin
         idx = 100 + k * 37;
         d = $urandom;
         txn(1'b0, 1'b1, 4'b1111, 32'(idx) << 2, d, 32'h0, "rinit");
         mdl[idx] = d;
      end
      for (int t = 0; t < 40; t++) begin
         idx = 100 + int'($urandom_range(0, 7)) * 37;
         a = ($urandom & 32'hFFFF_F003) | (32'(idx) << 2);
         if ($urandom_range(0, 1) == 1) begin
            b = 4'($urandom_range(0, 15));
            d = $urandom;
            txn(1'b0, 1'b1, b, a, d, 32'h0, "rwr");
            for (int n = 0; n < 4; n++) begin
               if (b[n]) mdl[idx][8*n +: 8] = d[8*n +: 8];
            end
         end else begin
            txn(1'b0, 1'b0, 4'($urandom), a, $urandom, mdl[idx], "rrd");
         end
      end

      // Zero-latency instance with the request held across two reads.
      txn(1'b1, 1'b1, 4'b1111, 32'h40, 32'hCAFEF00D, 32'h0, "l0wr40");
      txn(1'b1, 1'b1, 4'b1111, 32'h44, 32'h0BADC0DE, 32'h0, "l0wr44");
      we = 1'b0; be = 4'b0000; addr = 32'h40; req0 = 1'b1;
      @(negedge clk);
      chk("l0_c2_rdy", {31'd0, rdy0}, 32'd1);
      chk("l0_c2_rd", rd0, 32'hCAFEF00D);
      addr = 32'h44;
      @(negedge clk);
      chk("l0_c3_rdy", {31'd0, rdy0}, 32'd0);
      @(negedge clk);
      chk("l0_c4_rdy", {31'd0, rdy0}, 32'd1);
      chk("l0_c4_rd", rd0, 32'h0BADC0DE);
      req0 = 1'b0;
      @(negedge clk);
      chk("l0_c5_rdy", {31'd0, rdy0}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
